// File: rtl/parity_frame_checker_v.sv
// ---------------------------------------------------------------------------
// parity_frame_checker_v
//
// Receives a serial frame of FRAME_LEN data bits followed by one parity bit.
// It computes the expected parity over the data bits and compares it with the
// received parity bit. When the parity bit has been taken, it reports the
// expected parity and a mismatch flag. Both values stay registered until the
// next completed frame or a reset.
//
// Parameters
//   FRAME_LEN  : data bits per frame (1..255)
//   PARITY_ODD : 0 = even parity, 1 = odd parity
//
// Ports
//   i_clk   : clock, all state changes on the rising edge
//   i_rst   : synchronous active-high reset
//   i_start : opens a new frame (also aborts and restarts an open frame)
//   i_valid : qualifies i_bit
//   i_bit   : serial data / parity bit
//   o_ready : a bit is accepted this cycle if i_valid is high (DATA, PARITY)
//   o_busy  : a frame is open (DATA, PARITY)
//   o_done  : one-cycle completion pulse (DONE state)
//   o_par   : expected parity bit of the last completed frame
//   o_err   : parity mismatch of the last completed frame
// ---------------------------------------------------------------------------
module parity_frame_checker_v #(
    parameter int FRAME_LEN  = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_valid,
    input  logic i_bit,
    output logic o_ready,
    output logic o_busy,
    output logic o_done,
    output logic o_par,
    output logic o_err
);

    // The counter must be able to hold the value FRAME_LEN itself.
    localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);
    localparam logic            PAR_INIT = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;
    logic             run_par;
    logic             run_par_n;
    logic             par_q;
    logic             par_n;
    logic             err_q;
    logic             err_n;
    logic             frame_open;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            run_par <= 1'b0;
            par_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            run_par <= run_par_n;
            par_q   <= par_n;
            err_q   <= err_n;
        end
    end

    // Next-state and datapath logic. A start request takes precedence in every
    // state: it (re)opens a frame and drops any bit presented in the same cycle.
    // Holding all values by default gives the stall behaviour for i_valid=0.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        run_par_n = run_par;
        par_n     = par_q;
        err_n     = err_q;
        cnt_inc   = cnt + 1'b1;

        if (i_start) begin
            state_n   = DATA;
            cnt_n     = '0;
            run_par_n = PAR_INIT;
        end else begin
            unique case (state)
                IDLE: begin
                    state_n = IDLE;
                end
                DATA: begin
                    if (i_valid) begin
                        run_par_n = run_par ^ i_bit;
                        cnt_n     = cnt_inc;
                        if (cnt_inc == LAST_CNT) begin
                            state_n = PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (i_valid) begin
                        par_n   = run_par;
                        err_n   = run_par ^ i_bit;
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Handshake and status outputs are pure decodes of the registered state.
    assign frame_open = (state == DATA) || (state == PARITY);
    assign o_ready    = frame_open;
    assign o_busy     = frame_open;
    assign o_done     = (state == DONE);
    assign o_par      = par_q;
    assign o_err      = err_q;

endmodule

// File: doc/parity_frame_checker_v.md
PARITY_FRAME_CHECKER_V -- requirements
Module: parity_frame_checker_v

Interface
REQ-001 Parameter FRAME_LEN, default 8, number of data bits per frame (legal range 1..255).
REQ-002 Parameter PARITY_ODD, default 0, parity sense (0 = even, 1 = odd).
REQ-003 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_start  input  1  frame start pulse; opens a new frame.
REQ-006 i_valid  input  1  serial bit qualifier.
REQ-007 i_bit  input  1  serial data or parity bit.
REQ-008 o_ready  output  1  high when a bit is accepted this cycle if i_valid is high.
REQ-009 o_busy  output  1  high while a frame is open (DATA or PARITY state).
REQ-010 o_done  output  1  one-cycle pulse marking frame completion.
REQ-011 o_par  output  1  expected parity bit of the last completed frame.
REQ-012 o_err  output  1  parity mismatch of the last completed frame.

Function
REQ-013 States SHALL be IDLE, DATA, PARITY and DONE, in a registered FSM.
REQ-014 A transfer SHALL occur on a cycle with i_valid=1 and o_ready=1; o_ready SHALL equal 1 exactly in DATA and PARITY.
REQ-015 IDLE: i_start=1 -> DATA; running parity register loaded with PARITY_ODD; bit counter cleared.
REQ-016 DATA: each transfer SHALL XOR i_bit into the running parity and increment the counter (width ceil(log2(FRAME_LEN+1))).
REQ-017 DATA: the transfer that makes the count equal to FRAME_LEN SHALL move the FSM to PARITY.
REQ-018 PARITY: a transfer SHALL move the FSM to DONE, registering o_par = running parity and o_err = i_bit XOR running parity.
REQ-019 DONE: SHALL last exactly one cycle with o_done=1, then go to IDLE; i_start in DONE SHALL be honoured as in IDLE (DONE -> DATA).
REQ-020 i_valid=0 in DATA or PARITY SHALL stall: no state, counter or parity change.
REQ-021 i_start=1 in DATA or PARITY SHALL abort the open frame and restart it (counter cleared, parity reloaded, state DATA), with no o_done and o_par/o_err unchanged; a concurrent i_valid bit in that cycle SHALL be discarded.
REQ-022 i_valid in IDLE or DONE SHALL be ignored (o_ready=0).
REQ-023 o_par and o_err SHALL hold their values from one o_done until the next o_done or reset.
REQ-024 Latency: o_done SHALL assert the cycle after the parity-bit transfer; minimum frame time is FRAME_LEN+2 cycles from i_start to o_done.
REQ-025 o_busy SHALL be 1 in DATA and PARITY only.

Reset
REQ-026 i_rst=1 at a clock edge SHALL force IDLE, clear the counter and parity register, and drive o_ready=0, o_busy=0, o_done=0, o_par=0, o_err=0.
REQ-027 Reset SHALL take priority over i_start and i_valid in the same cycle, and mid-frame reset SHALL discard the frame without o_done.

Verification
REQ-028 FRAME_LEN=8, even: start, bits 1,0,1,1,0,0,0,0, parity 1, i_valid continuous -> o_done at cycle 10 after start, o_par=1, o_err=0.
REQ-029 Same frame with parity bit 0 -> o_done pulse, o_par=1, o_err=1; both held through 5 idle cycles.
REQ-030 PARITY_ODD=1, bits all 0, parity 1 -> o_par=1, o_err=0; i_valid low 3 cycles mid-frame -> o_done delayed by exactly 3 cycles.
REQ-031 i_start after 4 data bits, then full 8-bit frame 11111111 + parity 0 (even) -> single o_done, o_err=0, no pulse for the aborted frame.
REQ-032 i_rst asserted after 5 data bits together with i_valid=1 -> next cycle all outputs 0, state IDLE; later bits with no i_start produce no o_done.
REQ-033 i_start in the DONE cycle -> o_done=1 that cycle and o_busy=1 the following cycle; back-to-back frames both reported correctly.
